// File: rtl/ifc_initiator_if.sv
// Command, register-port and response bundle for ifc_initiator.
// master = initiator side, slave = command source / register block side.
interface ifc_initiator_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 1
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic [ADDR_W-1:0] write_address;
   logic [DATA_W-1:0] write_data;
   logic              write_en;
   logic              write_rdy;

   logic [ADDR_W-1:0] read_address;
   logic              read_en;
   logic [DATA_W-1:0] read_data;
   logic              read_rdy;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [ADDR_W-1:0] rsp_addr;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
      input  write_rdy, read_data, read_rdy, rsp_ready,
      output cmd_ready,
      output write_address, write_data, write_en,
      output read_address, read_en,
      output rsp_valid, rsp_addr, rsp_data, rsp_err
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
      output write_rdy, read_data, read_rdy, rsp_ready,
      input  cmd_ready,
      input  write_address, write_data, write_en,
      input  read_address, read_en,
      input  rsp_valid, rsp_addr, rsp_data, rsp_err
   );
endinterface

// File: rtl/ifc_initiator.sv
// One-at-a-time command initiator for the 8x1 register block,
// with per-transfer timeout and completed-transaction counters.
module ifc_initiator #(
   parameter int ADDR_W  = 3,
   parameter int DATA_W  = 1,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   ifc_initiator_if.master  bus,
   output logic [CNT_W-1:0] wr_count,
   output logic [CNT_W-1:0] rd_count,
   output logic             timeout_err
);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [TW-1:0]     r_wait;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;
   logic [ADDR_W-1:0] r_raddr;
   logic [ADDR_W-1:0] r_rsp_addr;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_err;
   logic [CNT_W-1:0]  r_wr_count;
   logic [CNT_W-1:0]  r_rd_count;
   logic              r_tmo_err;

   logic w_accept;
   logic w_wfire;
   logic w_rfire;
   logic w_abort;
   logic w_rdy;
   logic w_tlim;

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_wfire  = 1'b0;
      w_rfire  = 1'b0;
      w_abort  = 1'b0;
      w_rdy    = (r_state == WRITE) ? bus.write_rdy : bus.read_rdy;
      // A zero TIMEOUT never reaches the limit, so waits are unbounded.
      w_tlim   = (TIMEOUT != 0) && (r_wait == TLIM);
      case (r_state)
         IDLE: begin
            if (bus.cmd_valid && !RST_N) begin
               w_accept = 1'b1;
               w_next   = bus.cmd_op ? READ : WRITE;
            end
         end
         WRITE: begin
            if (bus.write_rdy) begin
               w_wfire = 1'b1;
               w_next  = RESP;
            end else if (w_tlim) begin
               w_abort = 1'b1;
               w_next  = RESP;
            end
         end
         READ: begin
            if (bus.read_rdy) begin
               w_rfire = 1'b1;
               w_next  = RESP;
            end else if (w_tlim) begin
               w_abort = 1'b1;
               w_next  = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST_N) begin
         r_state    <= IDLE;
         r_wait     <= '0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_raddr    <= '0;
         r_rsp_addr <= '0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
         r_wr_count <= '0;
         r_rd_count <= '0;
         r_tmo_err  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_wait     <= '0;
            r_rsp_addr <= bus.cmd_addr;
            if (bus.cmd_op) begin
               r_raddr <= bus.cmd_addr;
            end else begin
               r_waddr <= bus.cmd_addr;
               r_wdata <= bus.cmd_wdata;
            end
         end
         if ((r_state == WRITE || r_state == READ) && !w_rdy)
            r_wait <= r_wait + 1'b1;
         if (w_wfire) begin
            r_wr_count <= r_wr_count + 1'b1;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
         end
         if (w_rfire) begin
            r_rd_count <= r_rd_count + 1'b1;
            r_rsp_data <= bus.read_data;
            r_rsp_err  <= 1'b0;
         end
         if (w_abort) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_tmo_err  <= 1'b1;
         end
      end
   end

   assign bus.cmd_ready     = (r_state == IDLE) && !RST_N;
   assign bus.write_en      = (r_state == WRITE);
   assign bus.read_en       = (r_state == READ);
   assign bus.write_address = r_waddr;
   assign bus.write_data    = r_wdata;
   assign bus.read_address  = r_raddr;
   assign bus.rsp_valid     = (r_state == RESP);
   assign bus.rsp_addr      = r_rsp_addr;
   assign bus.rsp_data      = r_rsp_data;
   assign bus.rsp_err       = r_rsp_err;
   assign wr_count          = r_wr_count;
   assign rd_count          = r_rd_count;
   assign timeout_err       = r_tmo_err;
endmodule

// File: tb/tb_ifc_initiator.sv
// Randomised scoreboard bench for ifc_initiator; the bench also
// plays the register block, stalling rdy by a per-command delay.
module tb_ifc_initiator;
   localparam int TMO = 16;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [15:0] wr_count;
   logic [15:0] rd_count;
   logic        timeout_err;

   always #5 CLK = ~CLK;

   ifc_initiator_if #(.ADDR_W(3), .DATA_W(1)) bus ();

   ifc_initiator #(
      .ADDR_W(3), .DATA_W(1), .TIMEOUT(TMO), .CNT_W(16)
   ) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .bus(bus),
      .wr_count(wr_count),
      .rd_count(rd_count),
      .timeout_err(timeout_err)
   );

   typedef struct {
      logic [2:0] addr;
      logic       data;
      logic       err;
      int         wc;
      int         rc;
      logic       terr;
   } rsp_t;

   typedef struct {
      logic       op;
      logic [2:0] addr;
      logic       wdata;
      int         delay;
      int         len;
   } en_t;

   rsp_t rq[$];
   en_t  eq[$];
   int   total = 0;
   int   bad   = 0;
   bit   model_mem[8];
   int   m_wc   = 0;
   int   m_rc   = 0;
   bit   m_terr = 0;
   bit   bp_mode = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference: a command fires iff rdy comes within TMO enable cycles.
   task automatic issue(input bit op, input bit [2:0] a, input bit wd,
                        input int d);
      en_t  e;
      rsp_t r;
      bit   fire;
      int   n;
      fire    = (d < TMO);
      e.op    = op;
      e.addr  = a;
      e.wdata = wd;
      e.delay = d;
      e.len   = fire ? d + 1 : TMO;
      r.addr  = a;
      r.err   = !fire;
      r.data  = (op && fire) ? model_mem[a] : 1'b0;
      if (fire) begin
         if (op) m_rc++;
         else begin
            m_wc++;
            model_mem[a] = wd;
         end
      end else m_terr = 1'b1;
      r.wc   = m_wc;
      r.rc   = m_rc;
      r.terr = m_terr;
      eq.push_back(e);
      rq.push_back(r);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_addr  = a;
      bus.cmd_wdata = wd;
      n = 0;
      while (!bus.cmd_ready && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 200) chk("cmd_accept_timeout", 1, 0);
      @(negedge CLK);
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 1'($urandom);
      bus.cmd_addr  = 3'($urandom);
      bus.cmd_wdata = 1'($urandom);
   endtask

   function automatic int pick_delay();
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) return $urandom_range(0, 3);
      if (r == 6) return TMO - 1;
      if (r == 7) return TMO;
      if (r == 8) return TMO + 9;
      return $urandom_range(0, 8);
   endfunction

   // Register-block responder: checks enable behaviour, drives rdy/data.
   en_t cur;
   int  rcnt = 0;
   bit  was_en = 0;
   bit  mem_rb[8];

   always @(negedge CLK) begin
      logic en;
      logic rdy;
      en = bus.write_en | bus.read_en;
      chk("en_exclusive", 32'(bus.write_en & bus.read_en), 0);
      if (en) begin
         if (!was_en) begin
            rcnt = 0;
            if (eq.size() == 0) begin
               chk("en_unexpected", 1, 0);
               cur.op = bus.read_en; cur.addr = '0; cur.wdata = 1'b0;
               cur.delay = 0; cur.len = 1;
            end else cur = eq.pop_front();
            chk("en_op", 32'(bus.read_en), 32'(cur.op));
         end else rcnt++;
         if (cur.op) chk("read_address", 32'(bus.read_address), 32'(cur.addr));
         else begin
            chk("write_address", 32'(bus.write_address), 32'(cur.addr));
            chk("write_data", 32'(bus.write_data), 32'(cur.wdata));
         end
         rdy = (rcnt >= cur.delay);
         bus.write_rdy = bus.write_en ? rdy : 1'($urandom);
         bus.read_rdy  = bus.read_en  ? rdy : 1'($urandom);
         if (bus.write_en && rdy) mem_rb[bus.write_address] = bus.write_data;
      end else begin
         if (was_en) chk("en_len", rcnt + 1, cur.len);
         bus.write_rdy = 1'($urandom);
         bus.read_rdy  = 1'($urandom);
      end
      bus.read_data = mem_rb[bus.read_address];
      was_en = en;
   end

   // Response monitor: pops the scoreboard at each handshake.
   int   hcnt = 0;
   bit   held = 0;
   logic [2:0] h_addr;
   logic       h_data;
   logic       h_err;

   always @(negedge CLK) begin
      logic rdy;
      rsp_t r;
      if (bus.rsp_valid && bp_mode) rdy = (hcnt >= 5);
      else rdy = ($urandom_range(0, 3) != 0);
      bus.rsp_ready = rdy;
      if (bus.rsp_valid) begin
         chk("cmd_ready_in_resp", 32'(bus.cmd_ready), 0);
         if (held) begin
            chk("hold_addr", 32'(bus.rsp_addr), 32'(h_addr));
            chk("hold_data", 32'(bus.rsp_data), 32'(h_data));
            chk("hold_err", 32'(bus.rsp_err), 32'(h_err));
         end
         if (rdy) begin
            hcnt = 0;
            held = 0;
            if (rq.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
               r = rq.pop_front();
               chk("rsp_addr", 32'(bus.rsp_addr), 32'(r.addr));
               chk("rsp_data", 32'(bus.rsp_data), 32'(r.data));
               chk("rsp_err", 32'(bus.rsp_err), 32'(r.err));
               chk("wr_count", 32'(wr_count), r.wc);
               chk("rd_count", 32'(rd_count), r.rc);
               chk("timeout_err", 32'(timeout_err), 32'(r.terr));
            end
         end else begin
            hcnt++;
            held   = 1;
            h_addr = bus.rsp_addr;
            h_data = bus.rsp_data;
            h_err  = bus.rsp_err;
         end
      end else begin
         hcnt = 0;
         held = 0;
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while ((rq.size() != 0 || bus.rsp_valid) && n < 500) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 500) chk("drain_timeout", 1, 0);
      @(negedge CLK);
   endtask

   initial begin
      int n;
      RST_N         = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
      chk("rst_write_en", 32'(bus.write_en), 0);
      chk("rst_read_en", 32'(bus.read_en), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_wr_count", 32'(wr_count), 0);
      chk("rst_rd_count", 32'(rd_count), 0);
      chk("rst_timeout_err", 32'(timeout_err), 0);
      RST_N = 1'b0;
      @(negedge CLK);
      chk("idle_cmd_ready", 32'(bus.cmd_ready), 1);

      issue(1'b0, 3'd5, 1'b1, 0);
      issue(1'b1, 3'd5, 1'b0, 0);
      issue(1'b0, 3'd2, 1'b0, 3);
      issue(1'b1, 3'd7, 1'b0, TMO + 9);
      issue(1'b1, 3'd7, 1'b0, TMO - 1);
      issue(1'b0, 3'd7, 1'b1, TMO);
      drain();
      bp_mode = 1;
      issue(1'b0, 3'd3, 1'b1, 1);
      issue(1'b1, 3'd3, 1'b0, 0);
      drain();
      bp_mode = 0;

      for (int i = 0; i < 250; i++) begin
         issue(1'($urandom), 3'($urandom), 1'($urandom), pick_delay());
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end
      drain();

      // Reset three cycles into a stalled write: no response may follow.
      begin
         en_t e;
         e.op = 1'b0; e.addr = 3'd2; e.wdata = 1'b1;
         e.delay = TMO + 9; e.len = 3;
         eq.push_back(e);
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 1'b0;
      bus.cmd_addr  = 3'd2;
      bus.cmd_wdata = 1'b1;
      n = 0;
      while (!bus.cmd_ready && n < 50) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 50) chk("rst_test_accept", 1, 0);
      @(negedge CLK);
      bus.cmd_valid = 1'b0;
      chk("stall_write_en", 32'(bus.write_en), 1);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      chk("mid_rst_write_en", 32'(bus.write_en), 0);
      chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 0);
      chk("mid_rst_wr_count", 32'(wr_count), 0);
      chk("mid_rst_rd_count", 32'(rd_count), 0);
      chk("mid_rst_timeout_err", 32'(timeout_err), 0);
      RST_N  = 1'b0;
      m_wc   = 0;
      m_rc   = 0;
      m_terr = 0;
      @(negedge CLK);
      chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 1);
      repeat (3) begin
         @(negedge CLK);
         chk("post_rst_no_rsp", 32'(bus.rsp_valid), 0);
      end

      for (int i = 0; i < 20; i++)
         issue(1'($urandom), 3'($urandom), 1'($urandom), pick_delay());
      drain();
      chk("eq_empty", eq.size(), 0);
      chk("rq_empty", rq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ifc_initiator.md
Name: ifc_initiator

Overview:
- Command-driven initiator for the 8-entry x 1-bit register interface: write port (address/data/en/rdy) and read port (address/en/data/rdy).
- Accepts one command at a time on a valid/ready command port and drives the matching enable with the ready handshake.
- Returns one response per command with read data or a timeout error.
- Sits in front of the register block; used by test wrappers and by on-chip controllers.

Parameters:
- ADDR_W, 3, register address width.
- DATA_W, 1, register data width.
- TIMEOUT, 16, maximum enable-asserted cycles without rdy before abort; 0 disables timeout.
- CNT_W, 16, width of the completed-transaction counters.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST_N  input  1  synchronous reset, active-high (asserted = 1) despite the suffix.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  input  1  0 = write, 1 = read.
- cmd_addr  input  ADDR_W  target address.
- cmd_wdata  input  DATA_W  write data; ignored for reads.
- write_address  output  ADDR_W  to register block.
- write_data  output  DATA_W  to register block.
- write_en  output  1  write enable.
- write_rdy  input  1  write port ready.
- read_address  output  ADDR_W  to register block.
- read_en  output  1  read enable.
- read_data  input  DATA_W  read value; valid in the read fire cycle.
- read_rdy  input  1  read port ready.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
- rsp_addr  output  ADDR_W  address of the completed command.
- rsp_data  output  DATA_W  read data; 0 for writes and errors.
- rsp_err  output  1  1 = command aborted by timeout.
- wr_count  output  CNT_W  completed writes; wraps.
- rd_count  output  CNT_W  completed reads; wraps.
- timeout_err  output  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset (RST_N = 1 at an edge):
  - State goes to IDLE.
  - All registered outputs go to 0: addresses, write_data, enables, rsp_*, counters, timeout_err.
  - cmd_ready = 0 while RST_N = 1.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - cmd_ready = 1 (combinational from state).
  - On accept, latch op/addr/wdata into the port address/data registers and go to WRITE (op = 0) or READ (op = 1).
  - Clear the wait counter.
- WRITE:
  - write_en = 1; write_address and write_data held stable.
  - Fire = write_en && write_rdy at an edge → wr_count += 1.
  - Go to RESP with rsp_err = 0 and rsp_data = 0.
- READ:
  - read_en = 1; read_address held stable.
  - Fire = read_en && read_rdy → capture read_data into rsp_data and increment rd_count.
  - Go to RESP with rsp_err = 0.
- Timeout in WRITE/READ (TIMEOUT > 0):
  - The wait counter increments each edge with rdy = 0.
  - Abort at the edge where rdy = 0 and wait counter = TIMEOUT-1, so the enable stays high for exactly TIMEOUT cycles.
  - On abort: go to RESP with rsp_err = 1, rsp_data = 0, set timeout_err; counters unchanged.
  - rdy arriving at that same edge counts as a fire, not a timeout.
- RESP:
  - rsp_valid = 1; rsp_addr/rsp_data/rsp_err held until rsp_ready.
  - On the handshake edge go to IDLE.
  - cmd_ready = 0 throughout RESP.
- Invariants:
  - write_en and read_en are never both 1.
  - Enables are asserted only in WRITE/READ.
  - Exactly one fire or one abort per command.
  - Exactly one response per accepted command.
- Latency: command accepted at edge 0 → enable high in cycle 1.
  - rdy = 1 in cycle 1 → rsp_valid in cycle 2.
  - rsp_ready = 1 in cycle 2 → IDLE in cycle 3.
  - Peak throughput is one command per 3 cycles.
- Counters wrap from 2^CNT_W-1 to 0 silently.
- Reset mid-operation:
  - Enables and rsp_valid drop at the reset edge.
  - The in-flight command is discarded with no response.

Test Plan:
- Write: after reset, write addr 5 data 1 with write_rdy = 1 → write_en high for exactly 1 cycle with write_address = 5 and write_data = 1; rsp_valid next cycle with rsp_addr = 5, rsp_err = 0; wr_count = 1.
- Read: read addr 5 with read_rdy = 1 and read_data = 1 → read_en high 1 cycle; rsp_data = 1, rsp_addr = 5; rd_count = 1; write_en stays 0.
- Stall: write addr 2 data 0, write_rdy low for 3 cycles then high → write_en high for 4 cycles, address/data stable; single completion; wr_count += 1.
- Timeout: read addr 7 with read_rdy held 0, TIMEOUT = 16 → read_en high for exactly 16 cycles then 0; rsp_err = 1, rsp_data = 0; timeout_err = 1 and stays 1 across later good commands; rd_count unchanged.
- Backpressure: rsp_ready held 0 for 5 cycles with a second cmd_valid pending → rsp_valid and rsp fields held; cmd_ready = 0; second command accepted only after the handshake.
- Reset: assert RST_N = 1 for 1 cycle during a stalled WRITE → write_en = 0 next cycle; no response; counters = 0; timeout_err = 0; cmd_ready = 1 once RST_N returns to 0.
